home_event_log: RTL and testbench

- Receive-side decoder for the home-automation controller's 3-bit status code stream `display`.
- The controller time-multiplexes six sensor/actuator conditions onto one code per clock in a 13-slot polling frame.
- This block reconstructs a persistent per-condition "active" vector from that stream, counts assertion events per condition, and queues timestamped assertion records for a host/UI reader.
- It sits downstream of the controller; its outputs feed status LEDs and a host read interface.

---
 rtl/home_event_log_pkg.sv | 24 ++
 rtl/home_event_log_if.sv | 14 +
 rtl/home_event_log_fifo.sv | 54 +++++
 rtl/home_event_log.sv | 105 ++++++++++
 tb/tb_home_event_log.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/home_event_log_pkg.sv
// Shared definitions for the home-automation event log: status codes,
// condition count and the queued event record layout.
package home_pkg;

  typedef enum logic [2:0] {
    CODE_NONE    = 3'd0,
    CODE_FDOOR   = 3'd1,
    CODE_RDOOR   = 3'd2,
    CODE_FIRE    = 3'd3,
    CODE_WIN     = 3'd4,
    CODE_HEAT    = 3'd5,
    CODE_COOL    = 3'd6,
    CODE_INVALID = 3'd7
  } code_t;

  localparam int NUM_COND = 6;
  localparam int EV_TW    = 16;

  typedef struct packed {
    logic [2:0]       code;
    logic [EV_TW-1:0] ts;
  } ev_rec_t;

endpackage

// File: rtl/home_event_log_if.sv
// Host read port of the event log: show-ahead head record, pop strobe, occupancy.
interface home_event_log_if #(
  parameter int TW    = 16,
  parameter int DEPTH = 8
);
  logic                     ev_valid;
  logic [2:0]               ev_code;
  logic [TW-1:0]            ev_time;
  logic                     ev_rd;
  logic [$clog2(DEPTH):0]   ev_level;

  modport master (output ev_valid, ev_code, ev_time, ev_level, input ev_rd);
  modport slave  (input ev_valid, ev_code, ev_time, ev_level, output ev_rd);
endinterface

// File: rtl/home_event_log_fifo.sv
// Synchronous show-ahead FIFO; a push while full is accepted only when a pop
// frees the head slot in the same cycle.
module home_event_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  logic          w_do_push, w_do_pop;

  always_comb begin
    o_full    = (r_level == L_FULL);
    o_empty   = (r_level == '0);
    o_level   = r_level;
    o_rdata   = r_mem[r_rptr];
    w_do_pop  = i_pop & ~o_empty;
    w_do_push = i_push & (~o_full | w_do_pop);
  end

  always_ff @(posedge Clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/home_event_log.sv
// Decodes the multiplexed status-code stream into per-condition active flags,
// saturating assertion counters and a timestamped assertion-record queue.
module home_event_log
  import home_pkg::*;
#(
  parameter int FRAME = 13,
  parameter int TW    = 16,
  parameter int DEPTH = 8,
  parameter int CW    = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [2:0]           code_in,
  input  logic                 clr,
  input  logic [2:0]           cnt_sel,
  output logic [CW-1:0]        cnt_out,
  output logic [NUM_COND-1:0]  active,
  home_event_log_if.master     ev,
  output logic                 ovf,
  output logic                 err
);
  localparam int TMW = $clog2(FRAME + 1);

  logic [TW-1:0]       r_ts;
  logic [NUM_COND-1:0] r_active;
  logic [TMW-1:0]      r_timer [NUM_COND];
  logic [CW-1:0]       r_cnt   [NUM_COND];
  logic                r_ovf, r_err;

  logic [NUM_COND-1:0] w_sight, w_new;
  logic                w_push, w_pop, w_full, w_empty, w_drop;
  logic [TW+2:0]       w_wdata, w_rdata;

  always_comb begin
    w_sight = '0;
    for (int unsigned k = 0; k < NUM_COND; k++)
      w_sight[k] = (code_in == 3'(k + 1));
    w_new   = w_sight & ~r_active;
    w_push  = |w_new;
    w_pop   = ev.ev_rd & ~w_empty;
    // A full FIFO only loses the record when no pop frees a slot this cycle.
    w_drop  = w_push & w_full & ~w_pop;
    w_wdata = {code_in, r_ts};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ts     <= '0;
      r_active <= '0;
      for (int unsigned k = 0; k < NUM_COND; k++) r_timer[k] <= '0;
    end else begin
      r_ts <= r_ts + TW'(1);
      for (int unsigned k = 0; k < NUM_COND; k++) begin
        if (w_sight[k]) begin
          r_timer[k]  <= TMW'(FRAME);
          r_active[k] <= 1'b1;
        end else if (r_timer[k] != '0) begin
          r_timer[k] <= r_timer[k] - TMW'(1);
          if (r_timer[k] == TMW'(1)) r_active[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      for (int unsigned k = 0; k < NUM_COND; k++) r_cnt[k] <= '0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_COND; k++)
        if (w_new[k] && r_cnt[k] != '1) r_cnt[k] <= r_cnt[k] + CW'(1);
      if (w_drop) r_ovf <= 1'b1;
      if (code_in == CODE_INVALID) r_err <= 1'b1;
    end
  end

  home_event_fifo #(
    .W     (TW + 3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (ev.ev_level)
  );

  always_comb begin
    cnt_out = '0;
    for (int unsigned k = 0; k < NUM_COND; k++)
      if (cnt_sel == 3'(k + 1)) cnt_out = r_cnt[k];
    active      = r_active;
    ovf         = r_ovf;
    err         = r_err;
    ev.ev_valid = ~w_empty;
    ev.ev_code  = w_rdata[TW+2:TW];
    ev.ev_time  = w_rdata[TW-1:0];
  end

endmodule

// File: tb/tb_home_event_log.sv
// Scoreboard bench for home_event_log: a sighting-time model predicts state,
// expected records are queued on write and compared when popped.
module tb_home_event_log;
  import home_pkg::*;

  localparam int FRAME = 13;
  localparam int TW    = EV_TW;
  localparam int DEPTH = 8;
  localparam int CW    = 8;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [2:0]    code_in = '0;
  logic          clr = 1'b0;
  logic [2:0]    cnt_sel = '0;
  logic [CW-1:0] cnt_out;
  logic [5:0]    active;
  logic          ovf, err;

  home_event_log_if #(.TW(TW), .DEPTH(DEPTH)) ev_bus ();

  home_event_log #(
    .FRAME (FRAME),
    .TW    (TW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .code_in (code_in),
    .clr     (clr),
    .cnt_sel (cnt_sel),
    .cnt_out (cnt_out),
    .active  (active),
    .ev      (ev_bus),
    .ovf     (ovf),
    .err     (err)
  );

  always #5 Clk = ~Clk;

  int      n_checks = 0;
  int      n_fail   = 0;
  int      cyc      = 0;
  int      last_seen [6];
  int      m_cnt     [6];
  bit      m_ovf, m_err;
  ev_rec_t sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_act(input int k);
    return (last_seen[k] >= 0) && ((cyc - last_seen[k]) <= FRAME);
  endfunction

  function automatic logic [5:0] m_active_vec();
    logic [5:0] v;
    for (int k = 0; k < 6; k++) v[k] = m_act(k);
    return v;
  endfunction

  task automatic check_state();
    int s;
    s = int'(cnt_sel);
    chk("active",   active, m_active_vec());
    chk("ev_valid", ev_bus.ev_valid, sb.size() > 0);
    chk("ev_level", ev_bus.ev_level, sb.size());
    chk("ovf",      ovf, m_ovf);
    chk("err",      err, m_err);
    chk("cnt_out",  cnt_out, (s >= 1 && s <= 6) ? m_cnt[s-1] : 0);
    if (sb.size() > 0) begin
      chk("head_code", ev_bus.ev_code, sb[0].code);
      chk("head_time", ev_bus.ev_time, sb[0].ts);
    end
  endtask

  task automatic cycle(input logic [2:0] c, input bit cl, input bit rd);
    ev_rec_t r;
    int      k;
    code_in      = c;
    clr          = cl;
    ev_bus.ev_rd = rd;
    cnt_sel      = 3'((cyc + 1) % 8);
    if (rd && sb.size() > 0) begin
      r = sb.pop_front();
      chk("pop_code", ev_bus.ev_code, r.code);
      chk("pop_time", ev_bus.ev_time, r.ts);
    end
    if (c >= 1 && c <= 6) begin
      k = int'(c) - 1;
      if (!m_act(k)) begin
        if (m_cnt[k] < 255) m_cnt[k]++;
        if (sb.size() < DEPTH) begin
          r.code = c;
          r.ts   = TW'(cyc);
          sb.push_back(r);
        end else begin
          m_ovf = 1'b1;
        end
      end
      last_seen[k] = cyc;
    end
    if (c == 3'd7) m_err = 1'b1;
    if (cl) begin
      for (int i = 0; i < 6; i++) m_cnt[i] = 0;
      m_ovf = 1'b0;
      m_err = 1'b0;
    end
    @(posedge Clk);
    #1;
    cyc++;
    check_state();
  endtask

  task automatic do_reset();
    Rst          = 1'b1;
    code_in      = '0;
    clr          = 1'b0;
    ev_bus.ev_rd = 1'b0;
    cnt_sel      = '0;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      last_seen[i] = -1000;
      m_cnt[i]     = 0;
    end
    m_ovf = 1'b0;
    m_err = 1'b0;
    sb.delete();
    check_state();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ev_bus.ev_rd = 1'b0;
    do_reset();

    // first event: code 1 sampled in cycle 5
    repeat (5) cycle(3'd0, 0, 0);
    cycle(3'd1, 0, 0);
    chk("active0_at6", active[0], 1'b1);
    cycle(3'd0, 0, 0);
    chk("valid_at7", ev_bus.ev_valid, 1'b1);
    chk("code_at7",  ev_bus.ev_code, 3'd1);
    chk("time_at7",  ev_bus.ev_time, 16'd5);
    cnt_sel = 3'd1;
    #1 chk("cnt1", cnt_out, 8'd1);
    repeat (14) cycle(3'd0, 0, 0);
    cycle(3'd0, 0, 1);

    // code 5 polled once per frame never drops
    for (int i = 0; i < 100; i++) cycle((i % 13 == 0) ? 3'd5 : 3'd0, 0, 0);
    repeat (20) cycle(3'd0, 0, 0);
    cnt_sel = 3'd5;
    #1 chk("cnt5", cnt_out, 8'd1);
    chk("lvl5", ev_bus.ev_level, 4'd1);
    cycle(3'd0, 0, 1);

    // code 2 on/off: counter saturation, FIFO full, overflow
    for (int i = 0; i < 300; i++) begin
      cycle(3'd2, 0, 0);
      repeat (14) cycle(3'd0, 0, 0);
    end
    cnt_sel = 3'd2;
    #1 chk("cnt2_sat", cnt_out, 8'd255);
    chk("lvl_full", ev_bus.ev_level, 4'd8);
    chk("ovf_set",  ovf, 1'b1);
    cycle(3'd2, 0, 1);
    chk("lvl_full_rw", ev_bus.ev_level, 4'd8);
    repeat (8) cycle(3'd0, 0, 1);
    chk("lvl_drained", ev_bus.ev_level, 4'd0);

    // invalid code, then clr
    repeat (14) cycle(3'd0, 0, 0);
    cycle(3'd4, 0, 0);
    cycle(3'd7, 0, 0);
    repeat (3) cycle(3'd0, 0, 0);
    chk("err_sticky", err, 1'b1);
    cycle(3'd0, 1, 0);
    chk("err_clr",  err, 1'b0);
    chk("ovf_clr",  ovf, 1'b0);
    chk("act3_kept", active[3], 1'b1);
    cnt_sel = 3'd2;
    #1 chk("cnt2_clr", cnt_out, 8'd0);

    // clr coincident with a new code-3 sighting
    cycle(3'd3, 1, 0);
    cnt_sel = 3'd3;
    #1 chk("cnt3_clr_win", cnt_out, 8'd0);
    chk("lvl_after_clr", ev_bus.ev_level, 4'd2);
    repeat (2) cycle(3'd0, 0, 1);

    // reset mid-operation
    repeat (14) cycle(3'd0, 0, 0);
    cycle(3'd2, 0, 0);
    cycle(3'd4, 0, 0);
    repeat (14) cycle(3'd0, 0, 0);
    cycle(3'd1, 0, 0);
    cycle(3'd3, 0, 0);
    chk("lvl_pre_rst", ev_bus.ev_level, 4'd4);
    chk("act_pre_rst", active, 6'b000101);
    do_reset();
    chk("lvl_post_rst", ev_bus.ev_level, 4'd0);
    chk("act_post_rst", active, 6'b000000);
    cycle(3'd6, 0, 0);
    chk("ts_restart", ev_bus.ev_time, 16'd0);
    cycle(3'd1, 0, 0);
    repeat (2) cycle(3'd0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
